pcm_pingpong_buf: RTL and testbench
===================================

Name: pcm_pingpong_buf

Overview:
- Parametrised double-buffered (ping-pong) PCM sample store between a streaming sample source and the processor's memory-mapped PCM window.
- Successor to the fixed 16-bit / 11-bit-address PCM memory window and 4-bit control/response PIO handshake; generalises data width, address width, channel count and frames per bank.
- Adds autonomous capture, bank swapping, full flags, acknowledge and overrun detection.

Parameters:
- DATA_W, 16, sample and MM data width in bits; multiple of 8.
- ADDR_W, 11, MM word-address width.
- CHANNELS, 2, interleaved channels per frame; at least 1.
- FRAMES, 512, frames per bank. Legal only when 2*FRAMES*CHANNELS <= 2**ADDR_W.
- BE_W, DATA_W/8, byteenable width (derived).

Ports:
- clk_clk  in  1  system clock
- reset_reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  sample valid
- in_ready  out  1  sample accepted when in_valid & in_ready
- in_data  in  DATA_W  sample, channel order 0..CHANNELS-1 repeating
- pcm_mem_mm_address  in  ADDR_W  word address
- pcm_mem_mm_chipselect  in  1  access select
- pcm_mem_mm_clken  in  1  access qualifier; access occurs only when chipselect & clken
- pcm_mem_mm_write  in  1  1 = write, 0 = read
- pcm_mem_mm_writedata  in  DATA_W  write data
- pcm_mem_mm_byteenable  in  BE_W  byte lanes for writes
- pcm_mem_mm_readdata  out  DATA_W  read data
- pccm_ctl_con_export  in  4  [0] capture enable, [1] ack bank0, [2] ack bank1, [3] soft clear
- pccm_rsp_con_export  out  4  [0] bank0 full, [1] bank1 full, [2] overrun (sticky), [3] active bank

Behaviour:
- Reset: all outputs 0, including in_ready, readdata and rsp. wr_ptr=0, active bank=0. RAM contents undefined.
- Memory map: bank b, word i occupies address b*FRAMES*CHANNELS + i. Addresses at or above 2*FRAMES*CHANNELS read 0 and ignore writes.
- Capture enable and ack bits are rising-edge detected (registered previous value). Soft clear is level-sensitive.
- in_ready = enable & !full[active] & !soft_clear, registered one cycle from those terms.
- Accepted sample: written at active base + wr_ptr; wr_ptr increments.
- Bank completion: on the write with wr_ptr = FRAMES*CHANNELS-1, in the same cycle:
  - full[active] set;
  - active toggles;
  - wr_ptr resets to 0.
- Stall: if full[new active] is 1, in_ready drops next cycle and capture stalls until that bank is acked.
- Overrun: set on any cycle with in_valid & enable & !in_ready. Sticky until soft clear.
- Ack rising edge on bank k clears full[k]. If the same cycle also completes bank k, completion wins and full[k] stays 1.
- Enable falling edge: capture pauses; wr_ptr and active bank are retained (no partial-bank flush).
- Soft clear (ctl[3]=1):
  - clears full[1:0], overrun, wr_ptr and active bank, and holds them at 0 while asserted;
  - in_ready=0 while asserted;
  - RAM is untouched.
- MM read: readdata is valid exactly 1 cycle after the accepted access and holds until the next read. Write cycles leave readdata unchanged.
- MM write: only the lanes enabled by byteenable are updated.
- Collisions on the same address in the same cycle:
  - capture write and MM write: capture data wins on all lanes;
  - read and write: the read returns the old data.
- rsp output is registered: it reflects state one cycle after each event.
- Full-flag behaviour is identical for CHANNELS=1. Channel 0 is always at even frame boundaries: wr_ptr mod CHANNELS.

Test Plan:
1. Defaults. Reset, enable, stream 2048 samples with in_valid=1 → bank0 full after sample 1024 (rsp=4'b1001). Then bank1 fills (rsp=4'b0011) and in_ready=0. MM read of address 0 returns sample 0 one cycle after the access; address 1023 returns sample 1023.
2. Overrun. Continue in_valid=1 with both banks full → rsp[2]=1 and stays 1 after ack bank0. Capture resumes at bank0 address 0. Soft clear gives rsp=0.
3. Ack/completion collision. Ack bank1 rising edge in the same cycle bank1 completes → full[1] remains 1.
4. Byte lanes. MM write 16'hABCD with byteenable=2'b01 over 16'h1234 → read returns 16'h12CD. Same-cycle capture write to that address → capture value is stored.
5. Parametrised instance DATA_W=32, ADDR_W=8, CHANNELS=4, FRAMES=8. Bank size 32; the swap happens after 32 samples; address 200 reads 0.
6. Mid-operation. Reset asserted mid-bank → outputs 0 immediately, asynchronously. After release, capture restarts at address 0 of bank0.

Source files
------------

// File: rtl/pcm_pingpong_buf.sv
// Ping-pong PCM sample store. A streaming source fills two banks alternately, and the
// processor reads or patches them through a word-addressed window with byte lanes.
module pcm_pingpong_buf #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 11,
  parameter int CHANNELS = 2,
  parameter int FRAMES   = 512,
  parameter int BE_W     = DATA_W / 8
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] pcm_mem_mm_address,
  input  logic              pcm_mem_mm_chipselect,
  input  logic              pcm_mem_mm_clken,
  input  logic              pcm_mem_mm_write,
  input  logic [DATA_W-1:0] pcm_mem_mm_writedata,
  input  logic [BE_W-1:0]   pcm_mem_mm_byteenable,
  output logic [DATA_W-1:0] pcm_mem_mm_readdata,
  input  logic [3:0]        pccm_ctl_con_export,
  output logic [3:0]        pccm_rsp_con_export
);

  localparam int BANK  = FRAMES * CHANNELS;
  localparam int DEPTH = 2 * BANK;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = (BANK > 1) ? $clog2(BANK) : 1;

  genvar gi;

  logic [2:0]       ctl_prev_reg;
  logic             enable_reg, enable_next;
  logic             active_reg, active_next;
  logic [1:0]       full_reg, full_next;
  logic             overrun_reg, overrun_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic             in_ready_reg, in_ready_next;
  logic             rd_valid_reg;

  logic             soft_clear;
  logic             en_rise, en_fall;
  logic [1:0]       ack_rise;
  logic             accept, complete;
  logic [IDX_W-1:0] cap_idx, mm_idx;
  logic             mm_in_range, mm_rd, mm_wr;
  logic [DATA_W-1:0] ram_q;

  assign soft_clear = pccm_ctl_con_export[3];
  assign en_rise    = pccm_ctl_con_export[0] & ~ctl_prev_reg[0];
  assign en_fall    = ~pccm_ctl_con_export[0] & ctl_prev_reg[0];
  assign ack_rise   = pccm_ctl_con_export[2:1] & ~ctl_prev_reg[2:1];

  assign accept   = in_valid & in_ready_reg;
  assign complete = accept & (wr_ptr_reg == PTR_W'(BANK - 1));
  assign cap_idx  = (active_reg ? IDX_W'(BANK) : '0) + IDX_W'(wr_ptr_reg);

  // Widen by one bit so a full 2**ADDR_W map still compares correctly.
  assign mm_in_range = ({1'b0, pcm_mem_mm_address} < (ADDR_W + 1)'(DEPTH));
  assign mm_idx      = pcm_mem_mm_address[IDX_W-1:0];
  assign mm_rd       = pcm_mem_mm_chipselect & pcm_mem_mm_clken & ~pcm_mem_mm_write & mm_in_range;
  assign mm_wr       = pcm_mem_mm_chipselect & pcm_mem_mm_clken & pcm_mem_mm_write & mm_in_range;

  always_comb begin
    enable_next = enable_reg;
    if (en_rise) begin
      enable_next = 1'b1;
    end else if (en_fall) begin
      enable_next = 1'b0;
    end
  end

  always_comb begin
    full_next    = full_reg;
    active_next  = active_reg;
    wr_ptr_next  = wr_ptr_reg;
    overrun_next = overrun_reg | (in_valid & enable_reg & ~in_ready_reg);
    if (soft_clear) begin
      full_next    = 2'b00;
      active_next  = 1'b0;
      wr_ptr_next  = '0;
      overrun_next = 1'b0;
    end else begin
      // Completion is applied after the ack so it wins when both hit the same bank.
      for (int k = 0; k < 2; k++) begin
        if (ack_rise[k]) begin
          full_next[k] = 1'b0;
        end
        if (complete && (active_reg == 1'(k))) begin
          full_next[k] = 1'b1;
        end
      end
      if (complete) begin
        active_next = ~active_reg;
        wr_ptr_next = '0;
      end else if (accept) begin
        wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      end
    end
  end

  // Built from next-state terms so ready drops in the cycle right after a swap into a full bank.
  assign in_ready_next = enable_next & ~full_next[active_next] & ~soft_clear;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      ctl_prev_reg <= '0;
      enable_reg   <= 1'b0;
      active_reg   <= 1'b0;
      full_reg     <= 2'b00;
      overrun_reg  <= 1'b0;
      wr_ptr_reg   <= '0;
      in_ready_reg <= 1'b0;
      rd_valid_reg <= 1'b0;
    end else begin
      ctl_prev_reg <= pccm_ctl_con_export[2:0];
      enable_reg   <= enable_next;
      active_reg   <= active_next;
      full_reg     <= full_next;
      overrun_reg  <= overrun_next;
      wr_ptr_reg   <= wr_ptr_next;
      in_ready_reg <= in_ready_next;
      if (pcm_mem_mm_chipselect && pcm_mem_mm_clken && !pcm_mem_mm_write) begin
        rd_valid_reg <= mm_in_range;
      end
    end
  end

  // One RAM per byte lane; the capture write is issued last so it wins an address collision.
  for (gi = 0; gi < BE_W; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] q_reg;

    always_ff @(posedge clk_clk) begin
      if (mm_wr && pcm_mem_mm_byteenable[gi]) begin
        mem[mm_idx] <= pcm_mem_mm_writedata[gi*8 +: 8];
      end
      if (accept) begin
        mem[cap_idx] <= in_data[gi*8 +: 8];
      end
      if (mm_rd) begin
        q_reg <= mem[mm_idx];
      end
    end

    assign ram_q[gi*8 +: 8] = q_reg;
  end

  assign in_ready            = in_ready_reg;
  assign pcm_mem_mm_readdata = rd_valid_reg ? ram_q : '0;
  assign pccm_rsp_con_export = {active_reg, overrun_reg, full_reg};

endmodule

// File: tb/tb_pcm_pingpong_buf.sv
// Bench for pcm_pingpong_buf: a default instance and a small 32-bit/4-channel instance,
// with read expectations queued at issue time and compared when readdata becomes valid.
module tb_pcm_pingpong_buf;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        a_in_valid, a_in_ready;
  logic [15:0] a_in_data;
  logic [10:0] a_addr;
  logic        a_cs, a_ce, a_wr;
  logic [15:0] a_wdata, a_rdata;
  logic [1:0]  a_be;
  logic [3:0]  a_ctl, a_rsp;

  logic        b_in_valid, b_in_ready;
  logic [31:0] b_in_data;
  logic [7:0]  b_addr;
  logic        b_cs, b_ce, b_wr;
  logic [31:0] b_wdata, b_rdata;
  logic [3:0]  b_be;
  logic [3:0]  b_ctl, b_rsp;

  pcm_pingpong_buf dut_a (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .pcm_mem_mm_address(a_addr), .pcm_mem_mm_chipselect(a_cs), .pcm_mem_mm_clken(a_ce),
    .pcm_mem_mm_write(a_wr), .pcm_mem_mm_writedata(a_wdata), .pcm_mem_mm_byteenable(a_be),
    .pcm_mem_mm_readdata(a_rdata), .pccm_ctl_con_export(a_ctl), .pccm_rsp_con_export(a_rsp)
  );

  pcm_pingpong_buf #(.DATA_W(32), .ADDR_W(8), .CHANNELS(4), .FRAMES(8)) dut_b (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .pcm_mem_mm_address(b_addr), .pcm_mem_mm_chipselect(b_cs), .pcm_mem_mm_clken(b_ce),
    .pcm_mem_mm_write(b_wr), .pcm_mem_mm_writedata(b_wdata), .pcm_mem_mm_byteenable(b_be),
    .pcm_mem_mm_readdata(b_rdata), .pccm_ctl_con_export(b_ctl), .pccm_rsp_con_export(b_rsp)
  );

  typedef struct {
    string       name;
    logic [10:0] addr;
    logic        cs;
    logic        ce;
    logic        wr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] exp;
  } vec_t;

  vec_t        tbl[12];
  logic [31:0] rd_q[$];
  int          n_vec = 0;
  int          n_miss = 0;
  int          sample_a = 0;
  int          sample_b = 0;

  function automatic logic [15:0] fa(input int n);
    return 16'(n * 37 + 256);
  endfunction

  function automatic logic [31:0] fb(input int n);
    return 32'hC0DE_0000 ^ 32'(n * 1013);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic mm_a(input string name, input logic [10:0] addr, input logic cs, input logic ce,
                      input logic wr, input logic [15:0] wd, input logic [1:0] be,
                      input logic [15:0] exp);
    a_addr = addr; a_cs = cs; a_ce = ce; a_wr = wr; a_wdata = wd; a_be = be;
    rd_q.push_back(32'(exp));
    tick();
    a_cs = 1'b0; a_ce = 1'b0; a_wr = 1'b0;
    check(name, 32'(a_rdata), rd_q.pop_front());
  endtask

  task automatic mm_b(input string name, input logic [7:0] addr, input logic wr,
                      input logic [31:0] wd, input logic [3:0] be, input logic [31:0] exp);
    b_addr = addr; b_cs = 1'b1; b_ce = 1'b1; b_wr = wr; b_wdata = wd; b_be = be;
    rd_q.push_back(exp);
    tick();
    b_cs = 1'b0; b_ce = 1'b0; b_wr = 1'b0;
    check(name, b_rdata, rd_q.pop_front());
  endtask

  // Leaves in_valid high; the caller drops it.
  task automatic stream_a(input int count);
    int acc;
    int cyc;
    logic fire;
    acc = 0;
    cyc = 0;
    a_in_valid = 1'b1;
    while (acc < count && cyc < count + 50) begin
      a_in_data = fa(sample_a);
      fire = a_in_ready;
      tick();
      cyc++;
      if (fire) begin
        acc++;
        sample_a++;
      end
    end
    check("stream_a_count", 32'(acc), 32'(count));
  endtask

  task automatic stream_b(input int count);
    int acc;
    int cyc;
    logic fire;
    acc = 0;
    cyc = 0;
    b_in_valid = 1'b1;
    while (acc < count && cyc < count + 50) begin
      b_in_data = fb(sample_b);
      fire = b_in_ready;
      tick();
      cyc++;
      if (fire) begin
        acc++;
        sample_b++;
      end
    end
    check("stream_b_count", 32'(acc), 32'(count));
  endtask

  initial begin
    int s0;
    rst_n = 1'b1;
    a_in_valid = 0; a_in_data = '0; a_addr = '0; a_cs = 0; a_ce = 0; a_wr = 0;
    a_wdata = '0; a_be = '0; a_ctl = '0;
    b_in_valid = 0; b_in_data = '0; b_addr = '0; b_cs = 0; b_ce = 0; b_wr = 0;
    b_wdata = '0; b_be = '0; b_ctl = '0;

    tbl[0]  = '{"rd_addr0",      11'd0,    1'b1, 1'b1, 1'b0, 16'h0000, 2'b00, fa(0)};
    tbl[1]  = '{"rd_addr1023",   11'd1023, 1'b1, 1'b1, 1'b0, 16'h0000, 2'b00, fa(1023)};
    tbl[2]  = '{"rd_addr1024",   11'd1024, 1'b1, 1'b1, 1'b0, 16'h0000, 2'b00, fa(1024)};
    tbl[3]  = '{"rd_addr2047",   11'd2047, 1'b1, 1'b1, 1'b0, 16'h0000, 2'b00, fa(2047)};
    tbl[4]  = '{"clken_low",     11'd5,    1'b1, 1'b0, 1'b0, 16'h0000, 2'b00, fa(2047)};
    tbl[5]  = '{"cs_low",        11'd5,    1'b0, 1'b1, 1'b0, 16'h0000, 2'b00, fa(2047)};
    tbl[6]  = '{"wr_hold_rd",    11'd10,   1'b1, 1'b1, 1'b1, 16'h1234, 2'b11, fa(2047)};
    tbl[7]  = '{"wr_lane0",      11'd10,   1'b1, 1'b1, 1'b1, 16'hABCD, 2'b01, fa(2047)};
    tbl[8]  = '{"rd_lane0_only", 11'd10,   1'b1, 1'b1, 1'b0, 16'h0000, 2'b00, 16'h12CD};
    tbl[9]  = '{"wr_lane1",      11'd10,   1'b1, 1'b1, 1'b1, 16'hFFFF, 2'b10, 16'h12CD};
    tbl[10] = '{"rd_lane1_only", 11'd10,   1'b1, 1'b1, 1'b0, 16'h0000, 2'b00, 16'hFFCD};
    tbl[11] = '{"rd_addr11",     11'd11,   1'b1, 1'b1, 1'b0, 16'h0000, 2'b00, fa(11)};

    #2 rst_n = 1'b0;
    tick();
    tick();
    check("reset_a_in_ready", 32'(a_in_ready), 32'd0);
    check("reset_a_rdata", 32'(a_rdata), 32'd0);
    check("reset_a_rsp", 32'(a_rsp), 32'd0);
    check("reset_b_rsp", 32'(b_rsp), 32'd0);
    check("reset_b_rdata", b_rdata, 32'd0);
    rst_n = 1'b1;
    tick();

    // Wide instance: 32-sample banks, out-of-range window.
    b_ctl = 4'b0001;
    tick();
    check("b_ready_after_enable", 32'(b_in_ready), 32'd1);
    stream_b(31);
    check("b_rsp_before_swap", 32'(b_rsp), 32'h0);
    stream_b(1);
    b_in_valid = 1'b0;
    check("b_rsp_after_swap", 32'(b_rsp), 32'h9);
    mm_b("b_rd_addr0", 8'd0, 1'b0, '0, 4'h0, fb(0));
    mm_b("b_rd_addr31", 8'd31, 1'b0, '0, 4'h0, fb(31));
    mm_b("b_wr_oob", 8'd200, 1'b1, 32'hFFFF_FFFF, 4'hF, fb(31));
    mm_b("b_rd_oob", 8'd200, 1'b0, '0, 4'h0, 32'h0);
    mm_b("b_wr_lane2", 8'd5, 1'b1, 32'hAABB_CCDD, 4'b0100, 32'h0);
    mm_b("b_rd_lane2", 8'd5, 1'b0, '0, 4'h0, (fb(5) & 32'hFF00_FFFF) | 32'h00BB_0000);

    // Fill both default banks.
    a_ctl = 4'b0001;
    tick();
    check("a_ready_after_enable", 32'(a_in_ready), 32'd1);
    stream_a(1024);
    check("a_bank0_full", 32'(a_rsp), 32'h9);
    stream_a(1024);
    a_in_valid = 1'b0;
    check("a_both_full", 32'(a_rsp), 32'h3);
    check("a_ready_both_full", 32'(a_in_ready), 32'd0);

    for (int i = 0; i < 12; i++) begin
      mm_a(tbl[i].name, tbl[i].addr, tbl[i].cs, tbl[i].ce, tbl[i].wr,
           tbl[i].wdata, tbl[i].be, tbl[i].exp);
    end

    // Overrun, then ack bank0 and resume at bank0 address 0.
    a_in_valid = 1'b1;
    tick();
    tick();
    a_in_valid = 1'b0;
    check("a_overrun_set", 32'(a_rsp), 32'h7);
    a_ctl = 4'b0011;
    tick();
    a_ctl = 4'b0001;
    check("a_ack0_rsp", 32'(a_rsp), 32'h6);
    check("a_ack0_ready", 32'(a_in_ready), 32'd1);
    s0 = sample_a;
    a_in_valid = 1'b1;
    a_in_data = fa(s0);
    tick();
    a_in_data = fa(s0 + 1);
    mm_a("cap_vs_rd_old", 11'd1, 1'b1, 1'b1, 1'b0, 16'h0, 2'b00, fa(1));
    a_in_data = fa(s0 + 2);
    mm_a("cap_vs_mm_wr", 11'd2, 1'b1, 1'b1, 1'b1, 16'hDEAD, 2'b11, fa(1));
    a_in_valid = 1'b0;
    sample_a = s0 + 3;
    mm_a("rd_cap_won", 11'd2, 1'b1, 1'b1, 1'b0, 16'h0, 2'b00, fa(s0 + 2));
    mm_a("rd_resume_1", 11'd1, 1'b1, 1'b1, 1'b0, 16'h0, 2'b00, fa(s0 + 1));
    mm_a("rd_resume_0", 11'd0, 1'b1, 1'b1, 1'b0, 16'h0, 2'b00, fa(s0));
    check("a_overrun_sticky", 32'(a_rsp), 32'h6);

    // Soft clear holds state at zero and blocks capture while asserted.
    a_ctl = 4'b1001;
    tick();
    check("soft_rsp", 32'(a_rsp), 32'h0);
    check("soft_ready", 32'(a_in_ready), 32'd0);
    tick();
    check("soft_ready_held", 32'(a_in_ready), 32'd0);
    a_ctl = 4'b0001;
    tick();
    check("soft_release_ready", 32'(a_in_ready), 32'd1);

    // Ack of bank1 lands on the cycle bank1 completes.
    stream_a(1024);
    check("c_bank0_full", 32'(a_rsp), 32'h9);
    stream_a(1023);
    check("c_ready_last", 32'(a_in_ready), 32'd1);
    a_in_data = fa(sample_a);
    a_ctl = 4'b0101;
    tick();
    sample_a++;
    a_in_valid = 1'b0;
    a_ctl = 4'b0001;
    check("ack_vs_complete", 32'(a_rsp), 32'h3);
    tick();
    a_ctl = 4'b0101;
    tick();
    a_ctl = 4'b0001;
    check("ack_bank1", 32'(a_rsp), 32'h1);
    check("ack_bank1_ready", 32'(a_in_ready), 32'd0);
    a_ctl = 4'b0011;
    tick();
    a_ctl = 4'b0001;
    check("ack_bank0_rsp", 32'(a_rsp), 32'h0);

    // Asynchronous reset in the middle of a bank.
    s0 = sample_a;
    stream_a(5);
    a_in_valid = 1'b0;
    mm_a("pre_reset_rd", 11'd0, 1'b1, 1'b1, 1'b0, 16'h0, 2'b00, fa(s0));
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_ready", 32'(a_in_ready), 32'd0);
    check("async_rst_rdata", 32'(a_rdata), 32'd0);
    check("async_rst_rsp", 32'(a_rsp), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", 32'(a_in_ready), 32'd1);
    s0 = sample_a;
    stream_a(1);
    a_in_valid = 1'b0;
    mm_a("post_rst_addr0", 11'd0, 1'b1, 1'b1, 1'b0, 16'h0, 2'b00, fa(s0));
    check("post_rst_rsp", 32'(a_rsp), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
